// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the decoded control word that travels from decode
// to execute, plus the derived width and halt-flag position used by the
// issue queue.
package ctrl_pkg;

    // Decoded control fields. The first member is the MSB of the packed word.
    // The halt flag is kept at the top so its bit position stays stable when
    // fields lower in the struct change.
    typedef struct packed {
        logic        halt;
        logic        rf_we;
        logic        mem_re;
        logic        mem_we;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  alu_op;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [3:0]  op_type;
        logic [2:0]  w_type;
        logic [2:0]  r_type;
        logic [2:0]  imm_type;
        logic [31:0] mask;
        logic [3:0]  matmul_op;
        logic [3:0]  matmul_idx;
        logic [2:0]  branch_sel;
        logic [1:0]  synch_sel;
        logic [1:0]  flush_sel;
    } ctrl_word_t;

    localparam int CTRL_W   = $bits(ctrl_word_t);
    localparam int HALT_POS = CTRL_W - 1;

endpackage

// File: rtl/ctrl_issue_queue.sv
// ctrl_issue_queue
// FIFO of decoded control words between decode and execute. Each accepted
// word is tagged with a monotonically increasing sequence number. A flush
// empties the queue without disturbing the tag counter. Once a halt word is
// accepted, further enqueues are held off until it drains.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   decode-side handshake, in_ctrl is the packed word
//   out_valid/out_ready execute-side handshake, out_ctrl/out_tag are the head
//   flush               discard all entries (highest priority after reset)
//   count               current occupancy
//   almost_full         count >= AF_THRESH
//   halt_pending        a halt word is queued and not yet dequeued
module ctrl_issue_queue
    import ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CTRL_W    = ctrl_pkg::CTRL_W,
    parameter int TAG_W     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int HALT_BIT  = ctrl_pkg::HALT_POS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [TAG_W-1:0]           out_tag,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       halt_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pointer increment with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    logic [CTRL_W-1:0] ctrlMem_q [DEPTH];
    logic [TAG_W-1:0]  tagMem_q  [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] tagCnt_q, tagCnt_d;
    logic             halt_q, halt_d;

    logic enq;
    logic deq;

    // Handshake outputs depend on registered state only, so in_ready never
    // looks at in_valid.
    assign in_ready     = (count_q < CNT_W'(DEPTH)) & ~halt_q;
    assign out_valid    = (count_q != '0);
    assign out_ctrl     = ctrlMem_q[rdPtr_q];
    assign out_tag      = tagMem_q[rdPtr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign halt_pending = halt_q;

    assign enq = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    // Flush wins over any concurrent handshake but leaves the tag counter
    // alone so tags remain unique across redirects.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        tagCnt_d = tagCnt_q;
        halt_d   = halt_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            halt_d  = 1'b0;
        end else begin
            if (enq) begin
                wrPtr_d  = nextPtr(wrPtr_q);
                tagCnt_d = tagCnt_q + TAG_W'(1);
            end
            if (deq) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // An enqueue is impossible while a halt word is queued, so the
            // clear and set below never collide.
            if (deq && out_ctrl[HALT_BIT]) begin
                halt_d = 1'b0;
            end
            if (enq && in_ctrl[HALT_BIT]) begin
                halt_d = 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head outputs are never X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            tagCnt_q <= '0;
            halt_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrlMem_q[i] <= '0;
                tagMem_q[i]  <= '0;
            end
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            tagCnt_q <= tagCnt_d;
            halt_q   <= halt_d;
            if (enq && !flush) begin
                ctrlMem_q[wrPtr_q] <= in_ctrl;
                tagMem_q[wrPtr_q]  <= tagCnt_q;
            end
        end
    end

endmodule
